// File: rtl/lap_countdown_timer_if.sv
// Command, preset and display bundle for lap_countdown_timer.
// master drives commands and preset; slave returns segments and status pulses.
interface lap_countdown_timer_if;
    logic            timer_clear;
    logic            timer_reset;
    logic            timer_start;
    logic            timer_pause;
    logic            timer_lap;
    logic            count_down;
    logic [5:0][3:0] preset_bcd;
    logic [5:0][6:0] digital_clock_out;
    logic            running;
    logic            expired;
    logic            wrapped;
    logic            preset_err;

    modport master (
        output timer_clear, timer_reset, timer_start, timer_pause, timer_lap,
               count_down, preset_bcd,
        input  digital_clock_out, running, expired, wrapped, preset_err
    );

    modport slave (
        input  timer_clear, timer_reset, timer_start, timer_pause, timer_lap,
               count_down, preset_bcd,
        output digital_clock_out, running, expired, wrapped, preset_err
    );
endinterface

// File: rtl/lap_countdown_timer.sv
// HH:MM:SS up/down timer with tick prescaler, preset load, expiry/wrap pulses
// and a lap function that freezes the seven-segment display register.
module lap_countdown_timer #(
    parameter int TICK_DIV       = 100_000_000,
    parameter int MAX_HOURS      = 24,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input logic                  sys_clk,
    input logic                  rst,
    lap_countdown_timer_if.slave tif
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [5:0][3:0] cnt;
    logic [5:0][3:0] cnt_inc;
    logic [5:0][3:0] cnt_dec;
    logic [5:0][6:0] seg_q;
    logic            frozen;
    logic            frozen_nxt;
    logic            running_q;
    logic            expired_q;
    logic            wrapped_q;
    logic            preset_err_q;
    logic            tick;
    logic            at_max;
    logic            dec_zero;
    logic            preset_ok;
    logic [7:0]      cnt_hours;
    logic [7:0]      preset_hours;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    function automatic logic [5:0][6:0] seg_all(input logic [5:0][3:0] c);
        logic [5:0][6:0] r;
        for (int i = 0; i < 6; i++) r[i] = seg_of(c[i]);
        return r;
    endfunction

    assign tick = (state == RUNNING) && !tif.timer_pause && (presc == TICK_LAST);

    // BCD increment with 59/59 carries; at the top hour the whole count wraps to zero
    always_comb begin
        cnt_hours = 8'(cnt[5]) * 8'd10 + 8'(cnt[4]);
        at_max    = (cnt_hours == 8'(MAX_HOURS - 1)) && (cnt[3:0] == 16'h5959);
        cnt_inc   = cnt;
        if (at_max) begin
            cnt_inc = '0;
        end else if (cnt[0] != 4'd9) begin
            cnt_inc[0] = cnt[0] + 4'd1;
        end else begin
            cnt_inc[0] = 4'd0;
            if (cnt[1] != 4'd5) begin
                cnt_inc[1] = cnt[1] + 4'd1;
            end else begin
                cnt_inc[1] = 4'd0;
                if (cnt[2] != 4'd9) begin
                    cnt_inc[2] = cnt[2] + 4'd1;
                end else begin
                    cnt_inc[2] = 4'd0;
                    if (cnt[3] != 4'd5) begin
                        cnt_inc[3] = cnt[3] + 4'd1;
                    end else begin
                        cnt_inc[3] = 4'd0;
                        if (cnt[4] != 4'd9) begin
                            cnt_inc[4] = cnt[4] + 4'd1;
                        end else begin
                            cnt_inc[4] = 4'd0;
                            cnt_inc[5] = cnt[5] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // BCD decrement; a zero count saturates so a countdown never underflows
    always_comb begin
        cnt_dec = cnt;
        if (cnt == '0) begin
            cnt_dec = '0;
        end else if (cnt[0] != 4'd0) begin
            cnt_dec[0] = cnt[0] - 4'd1;
        end else begin
            cnt_dec[0] = 4'd9;
            if (cnt[1] != 4'd0) begin
                cnt_dec[1] = cnt[1] - 4'd1;
            end else begin
                cnt_dec[1] = 4'd5;
                if (cnt[2] != 4'd0) begin
                    cnt_dec[2] = cnt[2] - 4'd1;
                end else begin
                    cnt_dec[2] = 4'd9;
                    if (cnt[3] != 4'd0) begin
                        cnt_dec[3] = cnt[3] - 4'd1;
                    end else begin
                        cnt_dec[3] = 4'd5;
                        if (cnt[4] != 4'd0) begin
                            cnt_dec[4] = cnt[4] - 4'd1;
                        end else begin
                            cnt_dec[4] = 4'd9;
                            cnt_dec[5] = cnt[5] - 4'd1;
                        end
                    end
                end
            end
        end
        dec_zero = (cnt_dec == '0);
    end

    always_comb begin
        preset_hours = 8'(tif.preset_bcd[5]) * 8'd10 + 8'(tif.preset_bcd[4]);
        preset_ok    = (tif.preset_bcd[3] <= 4'd5) && (tif.preset_bcd[1] <= 4'd5) &&
                       (preset_hours < 8'(MAX_HOURS));
        for (int i = 0; i < 6; i++) begin
            if (tif.preset_bcd[i] > 4'd9) preset_ok = 1'b0;
        end
    end

    // Lap toggles only while running; leaving RUNNING always releases the freeze
    always_comb begin
        frozen_nxt = frozen;
        if (tif.timer_clear || tif.timer_reset) begin
            frozen_nxt = 1'b0;
        end else if (tif.timer_start && state == STOPPED) begin
            frozen_nxt = 1'b0;
        end else if (state == RUNNING) begin
            if (tif.timer_lap) frozen_nxt = !frozen;
            if (tick && tif.count_down && dec_zero) frozen_nxt = 1'b0;
        end
    end

    // The display reloads on the freeze and release edges too, so it shows the count at lap time
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= STOPPED;
            presc        <= '0;
            cnt          <= '0;
            frozen       <= 1'b0;
            seg_q        <= seg_all('0);
            running_q    <= 1'b0;
            expired_q    <= 1'b0;
            wrapped_q    <= 1'b0;
            preset_err_q <= 1'b0;
        end else begin
            expired_q    <= 1'b0;
            wrapped_q    <= 1'b0;
            preset_err_q <= 1'b0;
            frozen       <= frozen_nxt;
            if (!(frozen && frozen_nxt)) seg_q <= seg_all(cnt);
            if (tif.timer_clear) begin
                cnt       <= '0;
                presc     <= '0;
                state     <= STOPPED;
                running_q <= 1'b0;
            end else if (tif.timer_reset) begin
                if (preset_ok) cnt <= tif.preset_bcd;
                else           preset_err_q <= 1'b1;
                presc     <= '0;
                state     <= STOPPED;
                running_q <= 1'b0;
            end else if (tif.timer_start && state == STOPPED) begin
                presc     <= '0;
                state     <= RUNNING;
                running_q <= 1'b1;
            end else if (state == RUNNING && !tif.timer_pause) begin
                if (tick) begin
                    presc <= '0;
                    if (tif.count_down) begin
                        cnt <= cnt_dec;
                        if (dec_zero) begin
                            expired_q <= 1'b1;
                            state     <= EXPIRED;
                            running_q <= 1'b0;
                        end
                    end else begin
                        cnt       <= cnt_inc;
                        wrapped_q <= at_max;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    assign tif.digital_clock_out = seg_q;
    assign tif.running           = running_q;
    assign tif.expired           = expired_q;
    assign tif.wrapped           = wrapped_q;
    assign tif.preset_err        = preset_err_q;
endmodule

// File: doc/lap_countdown_timer.md
# lap_countdown_timer

Parametrised next-generation digital timer for the seven-segment display path: an HH:MM:SS counter with a programmable tick prescaler and a selectable count direction (up or down). It adds preset load, countdown expiry, up-count wrap flagging and a lap (display-freeze) function. It drives six seven-segment digits directly and sits between the system clock domain and the display driver.

## Interface
- `TICK_DIV`, default 100_000_000: `sys_clk` cycles per one-second tick; must be ≥ 2.
- `MAX_HOURS`, default 24: hours count range 0..MAX_HOURS-1; legal values 1..100.
- `SEG_ACTIVE_LOW`, default 0: 1 inverts every segment bit at the output.
- `sys_clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `timer_clear`  in  1  pulse: count ← 00:00:00, prescaler ← 0, state ← STOPPED, lap released.
- `timer_reset`  in  1  pulse: count ← `preset_bcd` if valid, prescaler ← 0, state ← STOPPED, lap released.
- `timer_start`  in  1  pulse: STOPPED → RUNNING.
- `timer_pause`  in  1  level: while high, ticks are suppressed and the prescaler holds.
- `timer_lap`  in  1  pulse: toggles display freeze (RUNNING only).
- `count_down`  in  1  level: 0 = up, 1 = down; sampled every tick.
- `preset_bcd`  in  6×4  BCD digits [5:0] = H tens, H units, M tens, M units, S tens, S units (digit 0 = S units).
- `digital_clock_out`  out  6×7  segment patterns, same digit order; bit0 = a … bit6 = g.
- `running`  out  1  high in RUNNING.
- `expired`  out  1  one-cycle pulse on countdown reaching zero.
- `wrapped`  out  1  one-cycle pulse on up-count rollover.
- `preset_err`  out  1  one-cycle pulse when `timer_reset` sees an invalid preset.

## Operation
- FSM states:
  - STOPPED (reset state).
  - RUNNING.
  - EXPIRED.
- FSM transitions:
  - STOPPED → RUNNING on `timer_start`.
  - RUNNING → EXPIRED when a down tick makes the count 00:00:00.
  - Any state → STOPPED on `timer_clear`/`timer_reset`.
  - `timer_start` has no effect in RUNNING or EXPIRED.
- Same-cycle priority: `rst` > `timer_clear` > `timer_reset` > `timer_start` > `timer_lap` > tick.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUNNING with `timer_pause` low; otherwise it holds.
  - A tick fires in the cycle the prescaler equals TICK_DIV-1; the prescaler then returns to 0.
- Up tick:
  - Seconds and minutes advance BCD-style 0..59, carrying into the next field.
  - At (MAX_HOURS-1):59:59 the count goes to 00:00:00, `wrapped` pulses and the FSM stays in RUNNING.
- Down tick:
  - Decrements with BCD borrow.
  - A tick at 00:00:01 yields 00:00:00, pulses `expired` and moves the FSM to EXPIRED.
  - Starting a countdown at 00:00:00: the first tick immediately expires and the count stays 00:00:00; there is no underflow.
- Preset validity: every digit ≤ 9, M tens ≤ 5, S tens ≤ 5, hours < MAX_HOURS. An invalid preset leaves the count unchanged and pulses `preset_err`; the FSM still goes to STOPPED.
- Lap:
  - The first `timer_lap` freezes the display register at its current value; the second releases it.
  - The count keeps running throughout.
  - The lap toggle is ignored outside RUNNING; STOPPED and EXPIRED force the display live.
- Segment encoding, active-high, for digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).

## Timing
- Count, FSM, `running`, `expired`, `wrapped` and `preset_err` are registered and update on the edge that completes the tick or command cycle.
- `digital_clock_out` is registered from the count: 1 cycle after the count changes.
- Reset values:
  - Count 00:00:00, prescaler 0, STOPPED, lap released.
  - `running`, `expired`, `wrapped` and `preset_err` all 0.
  - `digital_clock_out` = 3F on all digits (40 if SEG_ACTIVE_LOW); it reaches this value on the first post-reset edge.
- RUNNING from start: the first tick occurs TICK_DIV cycles after the `timer_start` edge.
- `rst` asserted mid-count overrides everything in that cycle.
- `count_down` changes take effect at the next tick; there is no other side effect.

## Test plan
- Reset: `rst` high 2 cycles → all digits 3F, all flags 0, `running`=0. With SEG_ACTIVE_LOW=1 → all digits 40.
- Up count (TICK_DIV=4): start, then 240 cycles → count 00:01:00; digit2 = 06, other digits 3F; `running`=1.
- Wrap (MAX_HOURS=24): preset 23:59:59, reset, start, 4 cycles → 00:00:00, `wrapped` high exactly 1 cycle, `running` stays 1.
- Countdown: preset 00:00:02, `count_down`=1, start, 8 cycles → `expired` pulses once, state EXPIRED, display 00:00:00. A later `timer_start` has no effect until `timer_clear`.
- Pause: assert `timer_pause` for 10 cycles after 2 prescaler counts → count frozen; after release, the next tick comes exactly 2 cycles later.
- Lap/preset error:
  - Lap at 00:00:03 → display holds 00:00:03 while the count advances; second lap at count 00:00:05 → display shows 00:00:05 one cycle later.
  - Preset 00:00:75 with `timer_reset` → `preset_err` pulses 1 cycle and the count is unchanged.
